hex_line_rx: RTL and testbench



---
 rtl/hex_line_rx_pkg.sv | 12 +
 rtl/hex_nibble_decode.sv | 34 +++
 rtl/hex_line_rx.sv | 87 ++++++++
 tb/tb_hex_line_rx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/hex_line_rx_pkg.sv
// Shared constants for the hex line receiver:
// line terminators and FSM state encoding.
package hex_line_rx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII byte classifier: hex digit
// to nibble, CR/LF terminator detect.
module hex_nibble_decode
  import hex_line_rx_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_hex,
  output logic       is_term,
  output logic [3:0] nibble
);

  // Letters a-f / A-F share low nibble 1..6, so +9 maps them to 10..15
  always_comb begin
    is_hex  = 1'b0;
    is_term = 1'b0;
    nibble  = 4'd0;
    unique case (1'b1)
      (data >= 8'h30 && data <= 8'h39): begin
        is_hex = 1'b1;
        nibble = data[3:0];
      end
      (data >= 8'h41 && data <= 8'h46),
      (data >= 8'h61 && data <= 8'h66): begin
        is_hex = 1'b1;
        nibble = data[3:0] + 4'd9;
      end
      (data == ASCII_CR || data == ASCII_LF): begin
        is_term = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hex_line_rx.sv
// Parses CR/LF terminated lines of ASCII hex digits
// from the UART byte stream into a binary word.
module hex_line_rx
  import hex_line_rx_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = WIDTH / 4,
  localparam int CW        = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data,
  input  logic             data_strobe,
  output logic [WIDTH-1:0] value,
  output logic [CW-1:0]    digits,
  output logic             value_strobe,
  output logic             error_strobe
);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic             is_hex;
  logic             is_term;
  logic [3:0]       nibble;

  hex_nibble_decode u_dec (
    .data    (data),
    .is_hex  (is_hex),
    .is_term (is_term),
    .nibble  (nibble)
  );

  // Line FSM: accumulate digits, publish on terminator, swallow bad lines
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      acc          <= '0;
      count        <= '0;
      value        <= '0;
      digits       <= '0;
      value_strobe <= 1'b0;
      error_strobe <= 1'b0;
    end else begin
      value_strobe <= 1'b0;
      error_strobe <= 1'b0;
      if (data_strobe) begin
        case (state)
          ST_IDLE: begin
            if (is_hex) begin
              acc   <= WIDTH'(nibble);
              count <= CW'(1);
              state <= ST_ACCUM;
            end else if (!is_term) begin
              error_strobe <= 1'b1;
              state        <= ST_DISCARD;
            end
          end
          ST_ACCUM: begin
            if (is_hex) begin
              if (count < CW'(MAX_DIGITS)) begin
                acc   <= (acc << 4) | WIDTH'(nibble);
                count <= count + 1'b1;
              end else begin
                error_strobe <= 1'b1;
                state        <= ST_DISCARD;
              end
            end else if (is_term) begin
              value        <= acc;
              digits       <= count;
              value_strobe <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              error_strobe <= 1'b1;
              state        <= ST_DISCARD;
            end
          end
          ST_DISCARD: begin
            if (is_term) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_line_rx.sv
// Directed bench for hex_line_rx: vector table plus
// gapped-line and mid-line reset sequences.
module tb_hex_line_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data;
  logic        data_strobe;
  logic [31:0] value;
  logic [3:0]  digits;
  logic        value_strobe;
  logic        error_strobe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  d;
    logic        s;
    logic        vs;
    logic        es;
    logic [31:0] v;
    logic [3:0]  n;
  } vec_t;

  vec_t vecs[$];

  hex_line_rx #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .data         (data),
    .data_strobe  (data_strobe),
    .value        (value),
    .digits       (digits),
    .value_strobe (value_strobe),
    .error_strobe (error_strobe)
  );

  always #5 clk = ~clk;

  function automatic void add(
    input logic [7:0] d, input logic s,
    input logic vs, input logic es,
    input logic [31:0] v, input logic [3:0] n
  );
    vec_t t;
    t.d = d; t.s = s; t.vs = vs;
    t.es = es; t.v = v; t.n = n;
    vecs.push_back(t);
  endfunction

  task automatic cyc(
    input logic [7:0] d, input logic s, input logic r
  );
    @(negedge clk);
    data = d;
    data_strobe = s;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string name, input logic vs, input logic es,
    input logic [31:0] v, input logic [3:0] n
  );
    checks++;
    if (value_strobe !== vs || error_strobe !== es ||
        value !== v || digits !== n) begin
      errors++;
      $display("FAIL %s: got vs=%b es=%b value=%h digits=%0d, want vs=%b es=%b value=%h digits=%0d",
               name, value_strobe, error_strobe, value, digits,
               vs, es, v, n);
    end
  endtask

  initial begin
    string line;
    string nm;
    reset = 1'b1;
    data = 8'h00;
    data_strobe = 1'b0;
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h31, 1'b1, 1'b1);
    check("reset", 1'b0, 1'b0, 32'h0, 4'd0);

    // empty lines from reset
    add(8'h0D, 1, 0, 0, 32'h0, 0);
    add(8'h0A, 1, 0, 0, 32'h0, 0);
    add(8'h0D, 1, 0, 0, 32'h0, 0);
    add(8'h0A, 1, 0, 0, 32'h0, 0);
    // "FfF\r\n" back-to-back
    add("F",   1, 0, 0, 32'h0, 0);
    add("f",   1, 0, 0, 32'h0, 0);
    add("F",   1, 0, 0, 32'h0, 0);
    add(8'h0D, 1, 1, 0, 32'h0fff, 3);
    add(8'h0A, 1, 0, 0, 32'h0fff, 3);
    // "12g4\r" rejected once
    add("1",   1, 0, 0, 32'h0fff, 3);
    add("2",   1, 0, 0, 32'h0fff, 3);
    add("g",   1, 0, 1, 32'h0fff, 3);
    add("4",   1, 0, 0, 32'h0fff, 3);
    add(8'h0D, 1, 0, 0, 32'h0fff, 3);
    // "5\n" with an idle hex byte in between
    add("5",   1, 0, 0, 32'h0fff, 3);
    add("7",   0, 0, 0, 32'h0fff, 3);
    add(8'h0A, 1, 1, 0, 32'h5, 1);
    // 9 digits overflow
    add("1",   1, 0, 0, 32'h5, 1);
    add("2",   1, 0, 0, 32'h5, 1);
    add("3",   1, 0, 0, 32'h5, 1);
    add("4",   1, 0, 0, 32'h5, 1);
    add("5",   1, 0, 0, 32'h5, 1);
    add("6",   1, 0, 0, 32'h5, 1);
    add("7",   1, 0, 0, 32'h5, 1);
    add("8",   1, 0, 0, 32'h5, 1);
    add("9",   1, 0, 1, 32'h5, 1);
    add(8'h0D, 1, 0, 0, 32'h5, 1);
    // junk in IDLE: one error, then silent discard
    add("z",   1, 0, 1, 32'h5, 1);
    add("Z",   1, 0, 0, 32'h5, 1);
    add("q",   1, 0, 0, 32'h5, 1);
    add(8'h0A, 1, 0, 0, 32'h5, 1);
    // short lines right-justified
    add("A",   1, 0, 0, 32'h5, 1);
    add("b",   1, 0, 0, 32'h5, 1);
    add(8'h0D, 1, 1, 0, 32'hab, 2);
    add("0",   1, 0, 0, 32'hab, 2);
    add(8'h0D, 1, 1, 0, 32'h0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].d, vecs[i].s, 1'b0);
      nm = $sformatf("vec%0d", i);
      check(nm, vecs[i].vs, vecs[i].es, vecs[i].v, vecs[i].n);
    end

    // full-width line with 16 idle cycles between bytes
    line = "1234abcd";
    for (int i = 0; i < 8; i++) begin
      cyc(line[i], 1'b1, 1'b0);
      nm = $sformatf("gap_byte%0d", i);
      check(nm, 1'b0, 1'b0, 32'h0, 4'd1);
      for (int k = 0; k < 16; k++) cyc(8'h0D, 1'b0, 1'b0);
      nm = $sformatf("gap_idle%0d", i);
      check(nm, 1'b0, 1'b0, 32'h0, 4'd1);
    end
    cyc(8'h0D, 1'b1, 1'b0);
    check("gap_cr", 1'b1, 1'b0, 32'h1234abcd, 4'd8);
    cyc(8'h00, 1'b0, 1'b0);
    check("gap_after", 1'b0, 1'b0, 32'h1234abcd, 4'd8);

    // reset mid-line beats a same-cycle CR
    cyc("1", 1'b1, 1'b0);
    cyc("2", 1'b1, 1'b0);
    check("rst_pre", 1'b0, 1'b0, 32'h1234abcd, 4'd8);
    cyc(8'h0D, 1'b1, 1'b1);
    check("rst_cyc", 1'b0, 1'b0, 32'h0, 4'd0);
    cyc("3", 1'b1, 1'b0);
    check("rst_3", 1'b0, 1'b0, 32'h0, 4'd0);
    cyc(8'h0D, 1'b1, 1'b0);
    check("rst_cr", 1'b1, 1'b0, 32'h3, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
